// File: rtl/fa_bist_checker.sv
// -----------------------------------------------------------------------------
// fa_bist_checker
//   Built-in self-test engine for a 1-bit full adder. It drives a/b/cin through
//   vectors 000..111 (a is the MSB), holds each vector for SETTLE_CYCLES cycles,
//   then samples s_in/cout_in for one cycle and compares them with the golden
//   full-adder result. A run is PASSES complete sweeps. At the end it reports
//   pass/fail, a saturating error count and the first failing vector.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          run request, level-sampled while idle
//   a, b, cin      operands driven into the adder under test
//   s_in, cout_in  adder results, sampled only in the CHECK cycle
//   busy           high while a run is in progress
//   done           one-cycle pulse at the end of a run
//   pass           last completed run had zero mismatches
//   err_count      saturating mismatch count of the current/last run
//   fail_valid     at least one mismatch captured this run
//   first_fail_vec {a,b,cin} of the first mismatch
// -----------------------------------------------------------------------------
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             s_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       first_fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PASSES - 1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0]  PC_ZERO  = PC_W'(0);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_ZERO = ERR_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Golden full-adder sum for vector {a,b,cin}.
  function automatic logic fa_sum(input logic [2:0] v);
    return v[2] ^ v[1] ^ v[0];
  endfunction

  // Golden full-adder carry (majority) for vector {a,b,cin}.
  function automatic logic fa_carry(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       vec_r, vec_s;
  logic [PC_W-1:0]  pass_cnt_r, pass_cnt_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       abc_r, abc_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             fail_valid_r, fail_valid_s;
  logic [2:0]       ffv_r, ffv_s;

  logic             mismatch_s;
  logic [ERR_W-1:0] err_inc_s;
  logic             last_s;

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s      = state_r;
    vec_s        = vec_r;
    pass_cnt_s   = pass_cnt_r;
    cnt_s        = cnt_r;
    abc_s        = abc_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    pass_s       = pass_r;
    err_s        = err_r;
    fail_valid_s = fail_valid_r;
    ffv_s        = ffv_r;

    // vec_r equals the driven vector during CHECK, so it is the golden index.
    mismatch_s = (s_in != fa_sum(vec_r)) | (cout_in != fa_carry(vec_r));
    if (err_r == ERR_MAX) begin
      err_inc_s = err_r;
    end else begin
      err_inc_s = err_r + ERR_ONE;
    end
    last_s = (vec_r == 3'd7) && (pass_cnt_r == PC_LAST);

    case (state_r)
      ST_IDLE: begin
        abc_s  = 3'b000;
        busy_s = 1'b0;
        if (start) begin
          state_s      = ST_SETTLE;
          vec_s        = 3'd0;
          pass_cnt_s   = PC_ZERO;
          cnt_s        = CNT_LOAD;
          err_s        = ERR_ZERO;
          fail_valid_s = 1'b0;
          ffv_s        = 3'd0;
          pass_s       = 1'b0;
          busy_s       = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        abc_s = vec_r;
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_CHECK: begin
        if (mismatch_s) begin
          err_s = err_inc_s;
          if (!fail_valid_r) begin
            fail_valid_s = 1'b1;
            ffv_s        = vec_r;
          end else begin
            ffv_s = ffv_r;
          end
        end else begin
          err_s = err_r;
        end

        if (last_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          abc_s   = 3'b000;
          // Must include the result of this final CHECK, hence err_s.
          pass_s  = (err_s == ERR_ZERO);
        end else begin
          state_s = ST_SETTLE;
          vec_s   = vec_r + 3'd1;
          abc_s   = vec_r + 3'd1;
          cnt_s   = CNT_LOAD;
          if (vec_r == 3'd7) begin
            pass_cnt_s = pass_cnt_r + PC_ONE;
          end else begin
            pass_cnt_s = pass_cnt_r;
          end
        end
      end

      ST_DONE: begin
        // start is ignored here; a held start is picked up from IDLE.
        state_s = ST_IDLE;
        abc_s   = 3'b000;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = ST_IDLE;
        abc_s   = 3'b000;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      vec_r        <= 3'd0;
      pass_cnt_r   <= PC_ZERO;
      cnt_r        <= CNT_ZERO;
      abc_r        <= 3'b000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= ERR_ZERO;
      fail_valid_r <= 1'b0;
      ffv_r        <= 3'd0;
    end else begin
      state_r      <= state_s;
      vec_r        <= vec_s;
      pass_cnt_r   <= pass_cnt_s;
      cnt_r        <= cnt_s;
      abc_r        <= abc_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_r        <= err_s;
      fail_valid_r <= fail_valid_s;
      ffv_r        <= ffv_s;
    end
  end

  assign a              = abc_r[2];
  assign b              = abc_r[1];
  assign cin            = abc_r[0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign fail_valid     = fail_valid_r;
  assign first_fail_vec = ffv_r;

endmodule

// File: tb/tb_fa_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_fa_bist_checker
//   Three checker instances (defaults, PASSES=2, SETTLE_CYCLES=3), each driving
//   a behavioural full adder whose outputs can be flipped per input vector by
//   the masks flip_s / flip_c to model faults.
// -----------------------------------------------------------------------------
module tb_fa_bist_checker;

  logic clk;
  logic rst_n;
  logic [2:0] start_w;
  logic [2:0] a_w, b_w, cin_w, s_w, c_w;
  logic [2:0] busy_w, done_w, pass_w, fv_w;
  logic [3:0] err_w [3];
  logic [2:0] ffv_w [3];

  logic [7:0] flip_s;
  logic [7:0] flip_c;

  int total;
  int bad;
  int sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adders under test with per-vector fault injection.
  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign s_w[i] = (a_w[i] ^ b_w[i] ^ cin_w[i]) ^ flip_s[{a_w[i], b_w[i], cin_w[i]}];
    assign c_w[i] = ((a_w[i] & b_w[i]) | (a_w[i] & cin_w[i]) | (b_w[i] & cin_w[i]))
                    ^ flip_c[{a_w[i], b_w[i], cin_w[i]}];
  end

  fa_bist_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]),
    .a(a_w[0]), .b(b_w[0]), .cin(cin_w[0]), .s_in(s_w[0]), .cout_in(c_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .fail_valid(fv_w[0]), .first_fail_vec(ffv_w[0]));

  fa_bist_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]),
    .a(a_w[1]), .b(b_w[1]), .cin(cin_w[1]), .s_in(s_w[1]), .cout_in(c_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .fail_valid(fv_w[1]), .first_fail_vec(ffv_w[1]));

  fa_bist_checker #(.SETTLE_CYCLES(3), .PASSES(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]),
    .a(a_w[2]), .b(b_w[2]), .cin(cin_w[2]), .s_in(s_w[2]), .cout_in(c_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
    .fail_valid(fv_w[2]), .first_fail_vec(ffv_w[2]));

  // Observed outputs of the currently selected instance.
  logic [2:0] abc_o;
  logic       busy_o, done_o, pass_o, fv_o;
  logic [3:0] err_o;
  logic [2:0] ffv_o;

  always_comb begin
    abc_o  = {a_w[sel], b_w[sel], cin_w[sel]};
    busy_o = busy_w[sel];
    done_o = done_w[sel];
    pass_o = pass_w[sel];
    fv_o   = fv_w[sel];
    err_o  = err_w[sel];
    ffv_o  = ffv_w[sel];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    start_w      = 3'b000;
    start_w[sel] = v;
  endtask

  function automatic int inst_settle(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int inst_passes(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // One complete run on instance sel: checks vector order, busy, done timing
  // and the final report. Called just after an active edge (+#1).
  task automatic run_check(input string nm, input int e_err, input int e_fv,
                           input int e_ffv, input int e_pass);
    int s;
    int n;
    int seq_bad;
    int early;
    s       = inst_settle(sel);
    n       = 8 * inst_passes(sel) * (s + 1);
    seq_bad = 0;
    early   = 0;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    chk({nm, ".start_busy"}, busy_o, 1);
    chk({nm, ".start_err"}, err_o, 0);
    chk({nm, ".start_fv"}, fv_o, 0);
    chk({nm, ".start_pass"}, pass_o, 0);
    for (int k = 0; k < n; k++) begin
      if (abc_o != 3'((k / (s + 1)) % 8)) seq_bad++;
      if (done_o || !busy_o) early++;
      @(posedge clk); #1;
    end
    chk({nm, ".vec_seq_bad"}, seq_bad, 0);
    chk({nm, ".busy_done_early"}, early, 0);
    chk({nm, ".done"}, done_o, 1);
    chk({nm, ".busy_end"}, busy_o, 0);
    chk({nm, ".abc_end"}, abc_o, 0);
    chk({nm, ".err"}, err_o, e_err);
    chk({nm, ".fail_valid"}, fv_o, e_fv);
    chk({nm, ".first_fail"}, ffv_o, e_ffv);
    chk({nm, ".pass"}, pass_o, e_pass);
    @(posedge clk); #1;
    chk({nm, ".done_pulse"}, done_o, 0);
    chk({nm, ".err_hold"}, err_o, e_err);
    chk({nm, ".pass_hold"}, pass_o, e_pass);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] fs;
    logic [7:0] fc;
    int         e_err;
    int         e_fv;
    int         e_ffv;
    int         e_pass;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int dones [$];
    int cnt;
    int e_err;
    int e_ffv;
    int guard;

    total   = 0;
    bad     = 0;
    sel     = 0;
    flip_s  = 8'h00;
    flip_c  = 8'h00;
    start_w = 3'b000;
    rst_n   = 1'b0;

    // inst, flip_s, flip_c, err, fail_valid, first_fail, pass
    tbl[0] = '{0, 8'h00, 8'h00, 0,  0, 0, 1};  // correct adder
    tbl[1] = '{0, 8'h00, 8'hE8, 4,  1, 3, 0};  // cout stuck at 0
    tbl[2] = '{1, 8'hFF, 8'h00, 15, 1, 0, 0};  // s inverted, 2 passes, saturates
    tbl[3] = '{2, 8'h00, 8'h00, 0,  0, 0, 1};  // 3 settle cycles, correct
    tbl[4] = '{0, 8'h80, 8'h80, 1,  1, 7, 0};  // only the last vector fails
    tbl[5] = '{0, 8'hFF, 8'h00, 8,  1, 0, 0};  // s inverted, single pass
    tbl[6] = '{1, 8'h00, 8'h10, 2,  1, 4, 0};  // vector 4 fails in both passes
    tbl[7] = '{2, 8'h24, 8'h00, 2,  1, 2, 0};  // vectors 2 and 5 fail

    #12;
    chk("reset.abc", abc_o, 0);
    chk("reset.busy", busy_o, 0);
    chk("reset.done", done_o, 0);
    chk("reset.pass", pass_o, 0);
    chk("reset.err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      sel    = tbl[i].inst;
      flip_s = tbl[i].fs;
      flip_c = tbl[i].fc;
      run_check($sformatf("tbl%0d", i), tbl[i].e_err, tbl[i].e_fv,
                tbl[i].e_ffv, tbl[i].e_pass);
    end

    // Reset asserted while vector 4 is being driven.
    sel    = 0;
    flip_s = 8'hFF;
    flip_c = 8'h00;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("midrst.pre_abc", abc_o, 4);
    chk("midrst.pre_err", err_o, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.abc", abc_o, 0);
    chk("midrst.busy", busy_o, 0);
    chk("midrst.done", done_o, 0);
    chk("midrst.pass", pass_o, 0);
    chk("midrst.err", err_o, 0);
    chk("midrst.fv", fv_o, 0);
    chk("midrst.ffv", ffv_o, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    flip_s = 8'h00;
    @(posedge clk); #1;
    chk("midrst.idle_busy", busy_o, 0);
    run_check("after_rst", 0, 0, 0, 1);

    // start held high: back-to-back runs, one IDLE cycle apart.
    sel    = 0;
    flip_c = 8'h00;
    set_start(1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 60; k++) begin
      if (done_o) dones.push_back(k);
      if (k == 17) chk("held.idle_busy", busy_o, 0);
      if (k == 34) begin
        chk("held.run2_err", err_o, 4);
        chk("held.run2_pass", pass_o, 0);
      end
      if (k == 36) begin
        chk("held.run3_err_clr", err_o, 0);
        chk("held.run3_busy", busy_o, 1);
      end
      if (k == 52) chk("held.run3_pass", pass_o, 1);
      if (k == 17) flip_c = 8'hE8;
      if (k == 35) flip_c = 8'h00;
      @(posedge clk); #1;
    end
    chk("held.done_count", dones.size(), 3);
    if (dones.size() == 3) begin
      chk("held.done0", dones[0], 16);
      chk("held.done1", dones[1], 34);
      chk("held.done2", dones[2], 52);
    end
    set_start(1'b0);
    guard = 0;
    while (busy_o && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("held.drain_timeout", busy_o, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Random per-vector faults against a counting model.
    for (int it = 0; it < 12; it++) begin
      sel    = int'($urandom_range(0, 2));
      flip_s = 8'($urandom & $urandom & $urandom);
      flip_c = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin
        flip_s = 8'h00;
        flip_c = 8'h00;
      end
      cnt   = $countones(flip_s | flip_c);
      e_err = cnt * inst_passes(sel);
      if (e_err > 15) e_err = 15;
      e_ffv = 0;
      for (int v = 7; v >= 0; v--) begin
        if (flip_s[v] || flip_c[v]) e_ffv = v;
      end
      run_check($sformatf("rnd%0d", it), e_err, (cnt > 0) ? 1 : 0, e_ffv,
                (cnt == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
